// File: rtl/word_framer_duplex.sv
// ============================================================================
// Module  : word_framer_duplex
// Brief   : Full-duplex word <-> byte framer between a word interface and UART.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module word_framer_duplex #(
  parameter int WORD_SIZE  = 12,
  parameter int UART_WIDTH = 8,
  parameter int MSB_FIRST  = 0,
  parameter int RX_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_word_valid,
  input  logic [WORD_SIZE-1:0]  tx_word,
  output logic                  tx_word_ready,
  output logic                  rx_word_valid,
  output logic [WORD_SIZE-1:0]  rx_word,
  output logic                  rx_timeout_err,
  output logic                  txByteStart,
  output logic [UART_WIDTH-1:0] byteForTx,
  input  logic                  txByteDone,
  input  logic                  rxByteValid,
  input  logic [UART_WIDTH-1:0] byteFromRx
);

  localparam int COUNT = (WORD_SIZE + UART_WIDTH - 1) / UART_WIDTH;
  localparam int BUF_W = COUNT * UART_WIDTH;
  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int TO_W  = $clog2(RX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(RX_TIMEOUT);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_t;

  typedef enum logic [0:0] {
    RX_IDLE    = 1'b0,
    RX_COLLECT = 1'b1
  } rx_state_t;

  // ---------------------------------------------------------------- TX path
  tx_state_t             tx_state_q, tx_state_d;
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic [BUF_W-1:0]      tx_buf_q, tx_buf_d;
  logic [BUF_W-1:0]      w_tx_word_ext;
  logic [CNT_W-1:0]      w_tx_slot;
  logic [UART_WIDTH-1:0] w_tx_byte;

  generate
    if (BUF_W > WORD_SIZE) begin : g_tx_pad
      assign w_tx_word_ext = {{(BUF_W - WORD_SIZE){1'b0}}, tx_word};
    end else begin : g_tx_nopad
      assign w_tx_word_ext = tx_word;
    end
  endgenerate

  assign w_tx_slot = (MSB_FIRST != 0) ? (LAST_IDX - tx_cnt_q) : tx_cnt_q;

  always_comb begin
    w_tx_byte = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (w_tx_slot == CNT_W'(i)) w_tx_byte = tx_buf_q[i*UART_WIDTH +: UART_WIDTH];
    end
  end

  always_comb begin
    tx_state_d    = tx_state_q;
    tx_cnt_d      = tx_cnt_q;
    tx_buf_d      = tx_buf_q;
    tx_word_ready = 1'b0;
    txByteStart   = 1'b0;
    byteForTx     = w_tx_byte;
    case (tx_state_q)
      TX_IDLE: begin
        tx_word_ready = 1'b1;
        if (tx_word_valid) begin
          tx_buf_d   = w_tx_word_ext;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        txByteStart = 1'b1;
        tx_state_d  = TX_WAIT;
      end
      TX_WAIT: begin
        if (txByteDone) begin
          if (tx_cnt_q == LAST_IDX) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_cnt_d   = tx_cnt_q + CNT_W'(1);
            tx_state_d = TX_START;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_buf_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_buf_q   <= tx_buf_d;
    end
  end

  // ---------------------------------------------------------------- RX path
  rx_state_t            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [TO_W-1:0]      rx_to_q, rx_to_d;
  logic [BUF_W-1:0]     rx_buf_q, rx_buf_d;
  logic [BUF_W-1:0]     w_rx_buf_ins;
  logic [CNT_W-1:0]     w_rx_slot;
  logic [WORD_SIZE-1:0] rx_word_q, rx_word_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_err_q, rx_err_d;

  assign w_rx_slot = (MSB_FIRST != 0) ? (LAST_IDX - rx_cnt_q) : rx_cnt_q;

  always_comb begin
    w_rx_buf_ins = rx_buf_q;
    for (int i = 0; i < COUNT; i++) begin
      if (w_rx_slot == CNT_W'(i)) w_rx_buf_ins[i*UART_WIDTH +: UART_WIDTH] = byteFromRx;
    end
  end

  // A byte takes priority over an expiring timeout in the same cycle.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_to_d    = rx_to_q;
    rx_buf_d   = rx_buf_q;
    rx_word_d  = rx_word_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    if (rxByteValid) begin
      rx_buf_d = w_rx_buf_ins;
      rx_to_d  = '0;
      if (rx_cnt_q == LAST_IDX) begin
        rx_word_d  = w_rx_buf_ins[WORD_SIZE-1:0];
        rx_valid_d = 1'b1;
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
      end else begin
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        rx_state_d = RX_COLLECT;
      end
    end else if (rx_state_q == RX_COLLECT) begin
      if (rx_to_q == TO_LIMIT) begin
        rx_err_d   = 1'b1;
        rx_cnt_d   = '0;
        rx_to_d    = '0;
        rx_state_d = RX_IDLE;
      end else begin
        rx_to_d = rx_to_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_to_q    <= '0;
      rx_buf_q   <= '0;
      rx_word_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_to_q    <= rx_to_d;
      rx_buf_q   <= rx_buf_d;
      rx_word_q  <= rx_word_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign rx_word        = rx_word_q;
  assign rx_word_valid  = rx_valid_q;
  assign rx_timeout_err = rx_err_q;

endmodule

`default_nettype wire

// File: tb/tb_word_framer_duplex.sv
// ============================================================================
// Module  : tb_word_framer_duplex
// Brief   : Self-checking bench: LSB-first and MSB-first framers, shared stimulus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_word_framer_duplex;

  localparam int TOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_word_valid;
  logic [11:0] tx_word;
  logic        txByteDone;
  logic        rxByteValid;
  logic [7:0]  byteFromRx;

  logic        a_ready, a_start, a_rvalid, a_err;
  logic [7:0]  a_byte;
  logic [11:0] a_rword;
  logic        b_ready, b_start, b_rvalid, b_err;
  logic [7:0]  b_byte;
  logic [11:0] b_rword;

  always #5 clk = ~clk;

  word_framer_duplex #(.WORD_SIZE(12), .UART_WIDTH(8), .MSB_FIRST(0), .RX_TIMEOUT(TOUT)) u_lsb (
    .clk(clk), .rst(rst),
    .tx_word_valid(tx_word_valid), .tx_word(tx_word), .tx_word_ready(a_ready),
    .rx_word_valid(a_rvalid), .rx_word(a_rword), .rx_timeout_err(a_err),
    .txByteStart(a_start), .byteForTx(a_byte), .txByteDone(txByteDone),
    .rxByteValid(rxByteValid), .byteFromRx(byteFromRx)
  );

  word_framer_duplex #(.WORD_SIZE(12), .UART_WIDTH(8), .MSB_FIRST(1), .RX_TIMEOUT(TOUT)) u_msb (
    .clk(clk), .rst(rst),
    .tx_word_valid(tx_word_valid), .tx_word(tx_word), .tx_word_ready(b_ready),
    .rx_word_valid(b_rvalid), .rx_word(b_rword), .rx_timeout_err(b_err),
    .txByteStart(b_start), .byteForTx(b_byte), .txByteDone(txByteDone),
    .rxByteValid(rxByteValid), .byteFromRx(byteFromRx)
  );

  // Reference model: a word becomes two bytes; RX gathers bytes in a queue and
  // drops them once more than TOUT silent cycles follow the last byte.
  logic        m_busy, m_start, m_fresh;
  int          m_idx;
  logic [11:0] m_word;
  logic [7:0]  m_byte_a, m_byte_b;
  logic [7:0]  m_q[$];
  int          m_gap;
  logic        m_rx_valid, m_rx_err;
  logic [11:0] ma_word, mb_word;

  always @(posedge clk) begin : model
    logic [15:0] ext;
    logic [15:0] pair;
    if (rst) begin
      m_busy = 0; m_start = 0; m_idx = 0; m_word = '0; m_fresh = 1;
      m_q.delete(); m_gap = 0; m_rx_valid = 0; m_rx_err = 0;
      ma_word = '0; mb_word = '0;
    end else begin
      if (!m_busy) begin
        if (tx_word_valid) begin
          m_word = tx_word; m_busy = 1; m_start = 1; m_idx = 0; m_fresh = 0;
        end
      end else if (m_start) begin
        m_start = 0;
      end else if (txByteDone) begin
        if (m_idx == 1) m_busy = 0;
        else begin m_idx = 1; m_start = 1; end
      end
      m_rx_valid = 0;
      m_rx_err   = 0;
      if (rxByteValid) begin
        m_q.push_back(byteFromRx);
        m_gap = 0;
        if (m_q.size() == 2) begin
          pair = {m_q[1], m_q[0]}; ma_word = pair[11:0];
          pair = {m_q[0], m_q[1]}; mb_word = pair[11:0];
          m_rx_valid = 1;
          m_q.delete();
        end
      end else if (m_q.size() != 0) begin
        m_gap++;
        if (m_gap > TOUT) begin
          m_rx_err = 1; m_q.delete(); m_gap = 0;
        end
      end
    end
    ext = {4'h0, m_word};
    m_byte_a = (m_idx == 0) ? ext[7:0]  : ext[15:8];
    m_byte_b = (m_idx == 0) ? ext[15:8] : ext[7:0];
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] capA[$];
  logic [7:0] capB[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one cycle, then compare every output with the model mid-cycle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("A.ready", a_ready, !m_busy);
    chk("B.ready", b_ready, !m_busy);
    chk("A.start", a_start, m_start);
    chk("B.start", b_start, m_start);
    if (m_busy || m_fresh) begin
      chk("A.byte", a_byte, m_byte_a);
      chk("B.byte", b_byte, m_byte_b);
    end
    chk("A.rvalid", a_rvalid, m_rx_valid);
    chk("B.rvalid", b_rvalid, m_rx_valid);
    chk("A.err", a_err, m_rx_err);
    chk("B.err", b_err, m_rx_err);
    chk("A.rword", a_rword, ma_word);
    chk("B.rword", b_rword, mb_word);
    if (a_start) capA.push_back(a_byte);
    if (b_start) capB.push_back(b_byte);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rxByteValid = 1; byteFromRx = b; tick(); rxByteValid = 0;
  endtask

  typedef struct { logic [11:0] w; logic [7:0] l0, l1, m0, m1; } tx_vec_t;
  typedef struct { logic [7:0] b0, b1; logic [11:0] wl, wm; } rx_vec_t;
  tx_vec_t txv[5];
  rx_vec_t rxv[5];

  initial begin
    int errs;
    int gap_left;
    txv[0] = '{12'hABC, 8'hBC, 8'h0A, 8'h0A, 8'hBC};
    txv[1] = '{12'h234, 8'h34, 8'h02, 8'h02, 8'h34};
    txv[2] = '{12'hFFF, 8'hFF, 8'h0F, 8'h0F, 8'hFF};
    txv[3] = '{12'h000, 8'h00, 8'h00, 8'h00, 8'h00};
    txv[4] = '{12'h801, 8'h01, 8'h08, 8'h08, 8'h01};
    rxv[0] = '{8'h34, 8'hF2, 12'h234, 12'h4F2};
    rxv[1] = '{8'h0A, 8'hBC, 12'hC0A, 12'hABC};
    rxv[2] = '{8'hFF, 8'hFF, 12'hFFF, 12'hFFF};
    rxv[3] = '{8'h01, 8'h80, 12'h001, 12'h180};
    rxv[4] = '{8'h5A, 8'hA5, 12'h55A, 12'hAA5};

    rst = 1; tx_word_valid = 0; tx_word = '0; txByteDone = 0; rxByteValid = 0; byteFromRx = '0;
    tick(); tick();
    chk("reset.ready", a_ready, 1);
    chk("reset.start", a_start, 0);
    chk("reset.byte", a_byte, 0);
    chk("reset.rword", a_rword, 0);
    chk("reset.rvalid", a_rvalid, 0);
    chk("reset.err", a_err, 0);
    rst = 0;

    // TX vectors, including the ready-low window until the second done
    for (int v = 0; v < 5; v++) begin
      capA.delete(); capB.delete();
      tx_word_valid = 1; tx_word = txv[v].w; tick(); tx_word_valid = 0;
      tick(); tick();
      txByteDone = 1; tick(); txByteDone = 0;
      chk("tx.ready_mid", a_ready, 0);
      tick();
      txByteDone = 1; tick(); txByteDone = 0;
      chk("tx.ready_end", a_ready, 1);
      chk("tx.countA", capA.size(), 2);
      chk("tx.countB", capB.size(), 2);
      if (capA.size() >= 2 && capB.size() >= 2) begin
        chk("tx.lsb0", capA[0], txv[v].l0);
        chk("tx.lsb1", capA[1], txv[v].l1);
        chk("tx.msb0", capB[0], txv[v].m0);
        chk("tx.msb1", capB[1], txv[v].m1);
      end
    end

    // RX vectors with a single completion pulse
    for (int v = 0; v < 5; v++) begin
      rx_byte(rxv[v].b0);
      tick(); tick();
      rx_byte(rxv[v].b1);
      chk("rx.validA", a_rvalid, 1);
      chk("rx.validB", b_rvalid, 1);
      chk("rx.wordA", a_rword, rxv[v].wl);
      chk("rx.wordB", b_rword, rxv[v].wm);
      tick();
      chk("rx.pulseA", a_rvalid, 0);
    end

    // Timeout: one byte then silence
    rx_byte(8'h77);
    errs = 0;
    for (int i = 0; i < TOUT; i++) begin tick(); if (a_err || b_err) errs++; end
    chk("to.early", errs, 0);
    tick();
    chk("to.errA", a_err, 1);
    chk("to.errB", b_err, 1);
    chk("to.keepA", a_rword, rxv[4].wl);
    tick();
    chk("to.pulse", a_err, 0);
    rx_byte(8'h34); rx_byte(8'hF2);
    chk("to.nextA", a_rword, 12'h234);
    chk("to.nextV", a_rvalid, 1);

    // Byte arriving on the exact timeout cycle wins
    rx_byte(8'h11);
    for (int i = 0; i < TOUT; i++) tick();
    rx_byte(8'h22);
    chk("edge.err", a_err, 0);
    chk("edge.valid", a_rvalid, 1);
    chk("edge.wordA", a_rword, 12'h211);
    chk("edge.wordB", b_rword, 12'h122);
    tick();
    chk("edge.noerr", a_err, 0);

    // Duplex start, then reset mid-TX and mid-RX
    tx_word_valid = 1; tx_word = 12'h5C3; rxByteValid = 1; byteFromRx = 8'h99;
    tick();
    tx_word_valid = 0; rxByteValid = 0;
    tick();
    rst = 1; tick();
    chk("rst.ready", a_ready, 1);
    chk("rst.start", a_start, 0);
    chk("rst.byte", a_byte, 0);
    chk("rst.rword", a_rword, 0);
    chk("rst.rvalid", a_rvalid, 0);
    rst = 0;
    errs = 0;
    for (int i = 0; i < TOUT + 4; i++) begin tick(); if (a_err || a_start) errs++; end
    chk("rst.quiet", errs, 0);
    rx_byte(8'hC3); rx_byte(8'h05);
    chk("rst.wordA", a_rword, 12'h5C3);
    chk("rst.wordB", b_rword, 12'h305);

    // Randomized duplex traffic against the model
    gap_left = 0;
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(0, 399) == 0);
      tx_word_valid = ($urandom_range(0, 3) == 0);
      tx_word       = 12'($urandom);
      txByteDone    = ($urandom_range(0, 2) == 0);
      if (gap_left == 0) begin
        rxByteValid = 1; byteFromRx = 8'($urandom);
        gap_left = $urandom_range(0, 20);
      end else begin
        rxByteValid = 0; gap_left--;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/word_framer_duplex.md
WORD_FRAMER_DUPLEX -- requirements
Module: word_framer_duplex

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 12, memory word width (>=1).
REQ-002 The block SHALL have parameter UART_WIDTH, default 8, byte width (>=1).
REQ-003 The block SHALL have parameter MSB_FIRST, default 0; 0 = least-significant byte first, 1 = most-significant byte first, for both TX and RX.
REQ-004 The block SHALL have parameter RX_TIMEOUT, default 1024, max idle cycles between bytes of one word (>=2).
REQ-005 The block SHALL derive COUNT = ceil(WORD_SIZE/UART_WIDTH) bytes per word and BUF_W = COUNT*UART_WIDTH.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-008 The block SHALL have port tx_word_valid, input, 1, word offered for transmit.
REQ-009 The block SHALL have port tx_word, input, WORD_SIZE, word to transmit.
REQ-010 The block SHALL have port tx_word_ready, output, 1, TX side idle and able to accept a word.
REQ-011 The block SHALL have port rx_word_valid, output, 1, one-cycle pulse: rx_word holds a complete word.
REQ-012 The block SHALL have port rx_word, output, WORD_SIZE, last assembled word; held until the next completes.
REQ-013 The block SHALL have port rx_timeout_err, output, 1, one-cycle pulse: partial word discarded.
REQ-014 The block SHALL have port txByteStart, output, 1, one-cycle pulse: launch byte to UART TX.
REQ-015 The block SHALL have port byteForTx, output, UART_WIDTH, byte to UART TX, stable from txByteStart until txByteDone.
REQ-016 The block SHALL have port txByteDone, input, 1, one-cycle pulse: UART TX has finished the byte.
REQ-017 The block SHALL have port rxByteValid, input, 1, one-cycle pulse: byteFromRx is valid.
REQ-018 The block SHALL have port byteFromRx, input, UART_WIDTH, received byte.

Function
REQ-019 TX and RX paths SHALL be independent FSMs and operate concurrently (full duplex).
REQ-020 TX FSM states SHALL be TX_IDLE, TX_START, TX_WAIT; tx_word_ready = 1 only in TX_IDLE.
REQ-021 In TX_IDLE with tx_word_valid = 1, the block SHALL latch tx_word zero-extended to BUF_W, clear the byte counter, and go to TX_START; txByteStart SHALL assert on the next cycle (latency 1).
REQ-022 TX_START SHALL assert txByteStart for exactly one cycle and go to TX_WAIT.
REQ-023 In TX_WAIT on txByteDone: if counter = COUNT-1, the block SHALL go to TX_IDLE; otherwise it SHALL increment the counter, select the next byte, and go to TX_START.
REQ-024 txByteDone outside TX_WAIT SHALL be ignored.
REQ-025 Byte k (k = 0..COUNT-1) sent SHALL be buffer slice k when MSB_FIRST = 0, and slice COUNT-1-k when MSB_FIRST = 1.
REQ-026 RX FSM states SHALL be RX_IDLE and RX_COLLECT.
REQ-027 On each rxByteValid, the block SHALL store byteFromRx into slice k (MSB_FIRST = 0) or slice COUNT-1-k (MSB_FIRST = 1), where k is the byte index within the word, and increment k.
REQ-028 When the COUNT-th byte is stored, the block SHALL update rx_word to the low WORD_SIZE bits of the buffer, pulse rx_word_valid on the following cycle, and return to RX_IDLE; padding bits SHALL be discarded.
REQ-029 COUNT = 1 SHALL complete a word on every rxByteValid without entering RX_COLLECT.
REQ-030 In RX_COLLECT, a timeout counter SHALL clear on each rxByteValid and increment otherwise.
REQ-031 When the timeout counter reaches RX_TIMEOUT, the block SHALL pulse rx_timeout_err for one cycle, clear k, leave rx_word unchanged, and go to RX_IDLE.
REQ-032 If rxByteValid coincides with the timeout cycle, the byte SHALL win: it is stored and no error is raised.
REQ-033 The byte after a completed or timed-out word SHALL start a new word at k = 0.

Reset
REQ-034 While rst = 1, the block SHALL force both FSMs to their idle states and clear all counters and buffers.
REQ-035 Reset values SHALL be: tx_word_ready = 1, txByteStart = 0, byteForTx = 0, rx_word = 0, rx_word_valid = 0, rx_timeout_err = 0.
REQ-036 rst asserted mid-word SHALL abandon any TX transfer or RX assembly in progress with no completion or error pulse.

Verification
REQ-037 LSB-first TX test: WORD_SIZE = 12, tx_word = 0xABC -> bytes 0xBC then 0x0A; tx_word_ready = 0 until the second txByteDone.
REQ-038 MSB-first test: MSB_FIRST = 1, tx_word = 0xABC -> bytes 0x0A then 0xBC; RX bytes 0x0A, 0xBC -> rx_word = 0xABC.
REQ-039 RX assembly test: LSB-first bytes 0x34, 0xF2 -> rx_word = 0x234 with a single rx_word_valid pulse.
REQ-040 Timeout test: RX_TIMEOUT = 16, one byte then silence -> rx_timeout_err pulses once; rx_word unchanged; the next two bytes form a clean word.
REQ-041 Duplex/boundary test: TX and RX active at the same time, a byte on the exact timeout cycle, and rst mid-TX -> no corruption, no error, and outputs return to reset values.
